// File: rtl/hit_arbiter_if.sv
// Hit-event handshake between hit_arbiter (master) and the game processor (slave).
interface hit_arbiter_if;
    logic        hit_valid;
    logic        hit_ready;
    logic        hit_target;
    logic [31:0] hit_knockback;
    logic [15:0] hit_damage;

    modport master (
        output hit_valid,
        output hit_target,
        output hit_knockback,
        output hit_damage,
        input  hit_ready
    );

    modport slave (
        input  hit_valid,
        input  hit_target,
        input  hit_knockback,
        input  hit_damage,
        output hit_ready
    );
endinterface

// File: rtl/hit_arbiter.sv
// Turns per-character level attack words into one-per-attack hit events, arbitrates
// them round-robin to the processor and owns each character's damage and invulnerability.
module hit_arbiter #(
    parameter int unsigned INVULN_FRAMES = 30,
    parameter int unsigned DMG_SMASH     = 12,
    parameter int unsigned DMG_JAB       = 3,
    parameter int unsigned DMG_SPECIAL   = 8,
    parameter int unsigned DMG_MAX       = 999
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic [31:0]          attack1,
    input  logic [31:0]          knockback1,
    input  logic [31:0]          attack2,
    input  logic [31:0]          knockback2,
    hit_arbiter_if.master        hit,
    output logic [15:0]          damage1,
    output logic [15:0]          damage2,
    output logic                 invuln1,
    output logic                 invuln2
);
    localparam logic [7:0]  LP_INV     = 8'(INVULN_FRAMES);
    localparam logic [15:0] LP_SMASH   = 16'(DMG_SMASH);
    localparam logic [15:0] LP_JAB     = 16'(DMG_JAB);
    localparam logic [15:0] LP_SPECIAL = 16'(DMG_SPECIAL);
    localparam logic [16:0] LP_MAX     = 17'(DMG_MAX);

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    state_t      r_state, w_state_next;
    logic        r_armed1, r_armed2, r_pend1, r_pend2;
    logic [31:0] r_kb1, r_kb2;
    logic [15:0] r_add1, r_add2;
    logic        r_rr;
    logic        r_hit_target;
    logic [31:0] r_hit_kb;
    logic [15:0] r_hit_dmg;
    logic [15:0] r_damage1, r_damage2;
    logic [7:0]  r_inv1, r_inv2;

    logic        w_cap1, w_cap2, w_grant1, w_grant2, w_accept;
    logic [16:0] w_sum;
    logic [15:0] w_sat;
    logic        w_unused;

    // Lowest set bit of attack[10:1] selects the damage class.
    function automatic logic [15:0] dmg_of(input logic [31:0] a);
        if (|a[4:1])       return LP_SMASH;
        else if (a[5])     return LP_JAB;
        else if (|a[10:6]) return LP_SPECIAL;
        else               return '0;
    endfunction

    assign invuln1 = (r_inv1 != '0);
    assign invuln2 = (r_inv2 != '0);
    assign w_cap1  = attack1[0] & r_armed1 & ~invuln2 & ~r_pend1;
    assign w_cap2  = attack2[0] & r_armed2 & ~invuln1 & ~r_pend2;

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_grant1     = 1'b0;
        w_grant2     = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // r_rr = 0 favours attacker 1; a lone requester always wins.
                if (r_pend1 && (!r_pend2 || !r_rr)) w_grant1 = 1'b1;
                else if (r_pend2)                   w_grant2 = 1'b1;
                if (w_grant1 || w_grant2) w_state_next = S_OFFER;
            end
            S_OFFER: begin
                if (hit.hit_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_sum = w_grant1 ? ({1'b0, r_damage2} + {1'b0, r_add1})
                            : ({1'b0, r_damage1} + {1'b0, r_add2});
    assign w_sat = (w_sum > LP_MAX) ? LP_MAX[15:0] : w_sum[15:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_armed1     <= 1'b1;
            r_armed2     <= 1'b1;
            r_pend1      <= 1'b0;
            r_pend2      <= 1'b0;
            r_kb1        <= '0;
            r_kb2        <= '0;
            r_add1       <= '0;
            r_add2       <= '0;
            r_rr         <= 1'b0;
            r_hit_target <= 1'b0;
            r_hit_kb     <= '0;
            r_hit_dmg    <= '0;
            r_damage1    <= '0;
            r_damage2    <= '0;
            r_inv1       <= '0;
            r_inv2       <= '0;
        end else begin
            if (!attack1[11]) r_armed1 <= 1'b1;
            else if (w_cap1)  r_armed1 <= 1'b0;
            if (!attack2[11]) r_armed2 <= 1'b1;
            else if (w_cap2)  r_armed2 <= 1'b0;

            if (w_cap1) begin
                r_pend1 <= 1'b1;
                r_kb1   <= knockback1;
                r_add1  <= dmg_of(attack1);
            end else if (w_grant1) begin
                r_pend1 <= 1'b0;
            end
            if (w_cap2) begin
                r_pend2 <= 1'b1;
                r_kb2   <= knockback2;
                r_add2  <= dmg_of(attack2);
            end else if (w_grant2) begin
                r_pend2 <= 1'b0;
            end

            if (w_grant1 || w_grant2) begin
                r_rr         <= w_grant1;
                r_hit_target <= w_grant1;
                r_hit_kb     <= w_grant1 ? r_kb1 : r_kb2;
                r_hit_dmg    <= w_sat;
            end

            // A load on acceptance takes precedence over the frame decrement.
            if (w_accept && !r_hit_target) begin
                r_damage1 <= r_hit_dmg;
                r_inv1    <= LP_INV;
            end else if (frame_tick && invuln1) begin
                r_inv1    <= r_inv1 - 8'd1;
            end
            if (w_accept && r_hit_target) begin
                r_damage2 <= r_hit_dmg;
                r_inv2    <= LP_INV;
            end else if (frame_tick && invuln2) begin
                r_inv2    <= r_inv2 - 8'd1;
            end
        end
    end

    assign hit.hit_valid     = (r_state == S_OFFER);
    assign hit.hit_target    = r_hit_target;
    assign hit.hit_knockback = r_hit_kb;
    assign hit.hit_damage    = r_hit_dmg;
    assign damage1           = r_damage1;
    assign damage2           = r_damage2;

    assign w_unused = &{1'b0, attack1[31:12], attack2[31:12]};
endmodule

// File: tb/tb_hit_arbiter.sv
// Directed self-checking bench for hit_arbiter: single hit, re-arm, trades,
// round-robin, backpressure, damage saturation and reset during an offer.
module tb_hit_arbiter;
    logic        clock;
    logic        reset;
    logic        frame_tick;
    logic [31:0] attack1, knockback1, attack2, knockback2;
    logic [15:0] damage1, damage2;
    logic        invuln1, invuln2;

    int unsigned n_checks;
    int unsigned n_errors;

    hit_arbiter_if bus ();

    hit_arbiter #(
        .INVULN_FRAMES (30),
        .DMG_SMASH     (12),
        .DMG_JAB       (3),
        .DMG_SPECIAL   (8),
        .DMG_MAX       (999)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .attack1    (attack1),
        .knockback1 (knockback1),
        .attack2    (attack2),
        .knockback2 (knockback2),
        .hit        (bus),
        .damage1    (damage1),
        .damage2    (damage2),
        .invuln1    (invuln1),
        .invuln2    (invuln2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        attack1       = '0;
        attack2       = '0;
        knockback1    = '0;
        knockback2    = '0;
        frame_tick    = 1'b0;
        bus.hit_ready = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic tick_frames(input int unsigned n);
        repeat (n) begin
            frame_tick = 1'b1;
            @(negedge clock);
            frame_tick = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic wait_offer(input string tag);
        int unsigned n = 0;
        while (!bus.hit_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_offer"}, {31'd0, bus.hit_valid}, 32'd1);
    endtask

    task automatic land(input int unsigned k, input logic [31:0] w, output logic [15:0] d);
        if (k == 1) attack1 = w;
        else        attack2 = w;
        wait_offer("land");
        d = bus.hit_damage;
        @(negedge clock);
        attack1 = '0;
        attack2 = '0;
        tick_frames(30);
    endtask

    initial begin
        int unsigned n_pulse, first, n_late;
        logic        prev;
        logic        s_tgt, s_iv2;
        logic [31:0] s_kb;
        logic [15:0] s_dmg, s_d2, d;

        n_checks = 0;
        n_errors = 0;
        do_reset();

        // Reset state
        check("rst_valid",  {31'd0, bus.hit_valid},  32'd0);
        check("rst_target", {31'd0, bus.hit_target}, 32'd0);
        check("rst_kb",     bus.hit_knockback,       32'd0);
        check("rst_dmg",    {16'd0, bus.hit_damage}, 32'd0);
        check("rst_d1",     {16'd0, damage1},        32'd0);
        check("rst_d2",     {16'd0, damage2},        32'd0);
        check("rst_inv",    {30'd0, invuln1, invuln2}, 32'd0);

        // Single smash held 100 cycles: one pulse, two cycles after assertion
        attack1 = 32'h809; knockback1 = 32'h0000_0800;
        n_pulse = 0; first = 0; prev = 1'b0;
        s_tgt = 0; s_kb = '0; s_dmg = '0; s_d2 = '0; s_iv2 = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            if (first != 0 && i == first + 1) begin
                s_d2  = damage2;
                s_iv2 = invuln2;
            end
            if (bus.hit_valid && !prev) begin
                n_pulse++;
                if (first == 0) begin
                    first = i;
                    s_tgt = bus.hit_target;
                    s_kb  = bus.hit_knockback;
                    s_dmg = bus.hit_damage;
                end
            end
            prev = bus.hit_valid;
        end
        check("single_pulses", n_pulse, 32'd1);
        check("single_latency", first, 32'd2);
        check("single_target", {31'd0, s_tgt}, 32'd1);
        check("single_kb", s_kb, 32'h800);
        check("single_dmg", {16'd0, s_dmg}, 32'd12);
        check("single_d2", {16'd0, s_d2}, 32'd12);
        check("single_inv2", {31'd0, s_iv2}, 32'd1);

        // Re-arm while victim still invulnerable: no hit
        attack1 = '0;
        @(negedge clock);
        attack1 = 32'h809;
        n_late = 0;
        repeat (10) begin
            @(negedge clock);
            if (bus.hit_valid) n_late++;
        end
        check("rearm_early_none", n_late, 32'd0);
        check("rearm_early_d2", {16'd0, damage2}, 32'd12);
        attack1 = '0;
        tick_frames(30);
        check("inv2_expired", {31'd0, invuln2}, 32'd0);
        attack1 = 32'h809;
        wait_offer("rearm");
        check("rearm_dmg", {16'd0, bus.hit_damage}, 32'd24);
        @(negedge clock);
        check("rearm_d2", {16'd0, damage2}, 32'd24);
        attack1 = '0;

        // Trade: both attackers land in the same cycle
        do_reset();
        attack1 = 32'h821; knockback1 = 32'h111;
        attack2 = 32'h809; knockback2 = 32'h222;
        wait_offer("trade1");
        check("trade1_target", {31'd0, bus.hit_target}, 32'd1);
        check("trade1_kb", bus.hit_knockback, 32'h111);
        check("trade1_dmg", {16'd0, bus.hit_damage}, 32'd3);
        @(negedge clock);
        check("trade_gap", {31'd0, bus.hit_valid}, 32'd0);
        wait_offer("trade2");
        check("trade2_target", {31'd0, bus.hit_target}, 32'd0);
        check("trade2_kb", bus.hit_knockback, 32'h222);
        check("trade2_dmg", {16'd0, bus.hit_damage}, 32'd12);
        @(negedge clock);
        check("trade_d1", {16'd0, damage1}, 32'd12);
        check("trade_d2", {16'd0, damage2}, 32'd3);
        attack1 = '0; attack2 = '0;
        tick_frames(30);

        // Lone attacker 1 hit moves the pointer to attacker 2
        attack1 = 32'h821;
        wait_offer("lone");
        check("lone_target", {31'd0, bus.hit_target}, 32'd1);
        check("lone_dmg", {16'd0, bus.hit_damage}, 32'd6);
        @(negedge clock);
        attack1 = '0;
        tick_frames(30);
        attack1 = 32'h821; attack2 = 32'h809;
        wait_offer("rr1");
        check("rr1_target", {31'd0, bus.hit_target}, 32'd0);
        check("rr1_dmg", {16'd0, bus.hit_damage}, 32'd24);
        @(negedge clock);
        wait_offer("rr2");
        check("rr2_target", {31'd0, bus.hit_target}, 32'd1);
        check("rr2_dmg", {16'd0, bus.hit_damage}, 32'd9);
        @(negedge clock);
        attack1 = '0; attack2 = '0;
        tick_frames(30);

        // Backpressure: offer held stable, damage updates only on acceptance
        bus.hit_ready = 1'b0;
        attack2 = 32'h841; knockback2 = 32'hABCD;
        wait_offer("bp");
        check("bp_target", {31'd0, bus.hit_target}, 32'd0);
        check("bp_kb", bus.hit_knockback, 32'hABCD);
        check("bp_dmg", {16'd0, bus.hit_damage}, 32'd32);
        repeat (10) begin
            @(negedge clock);
            check("bp_valid", {31'd0, bus.hit_valid}, 32'd1);
            check("bp_hold", {bus.hit_damage, bus.hit_knockback[15:0]}, {16'd32, 16'hABCD});
            check("bp_target_hold", {31'd0, bus.hit_target}, 32'd0);
            check("bp_d1_hold", {16'd0, damage1}, 32'd24);
        end
        bus.hit_ready = 1'b1;
        @(negedge clock);
        check("bp_d1_after", {16'd0, damage1}, 32'd32);
        check("bp_valid_after", {31'd0, bus.hit_valid}, 32'd0);
        attack2 = '0;
        tick_frames(30);

        // Saturation at DMG_MAX
        do_reset();
        repeat (124) land(1, 32'h841, d);
        check("sat_pre992", {16'd0, damage2}, 32'd992);
        land(1, 32'h821, d);
        check("sat_pre995", {16'd0, damage2}, 32'd995);
        land(1, 32'h809, d);
        check("sat_hit_dmg", {16'd0, d}, 32'd999);
        check("sat_d2", {16'd0, damage2}, 32'd999);
        land(1, 32'h809, d);
        check("sat_again_dmg", {16'd0, d}, 32'd999);
        check("sat_again_d2", {16'd0, damage2}, 32'd999);

        // Reset during an offer discards the pending hit
        bus.hit_ready = 1'b0;
        attack1 = 32'h809; knockback1 = 32'h5A5A;
        wait_offer("rstoffer");
        reset = 1'b1;
        attack1 = '0;
        @(negedge clock);
        check("rstoffer_valid", {31'd0, bus.hit_valid}, 32'd0);
        check("rstoffer_target", {31'd0, bus.hit_target}, 32'd0);
        check("rstoffer_kb", bus.hit_knockback, 32'd0);
        check("rstoffer_dmg", {16'd0, bus.hit_damage}, 32'd0);
        check("rstoffer_d1", {16'd0, damage1}, 32'd0);
        check("rstoffer_d2", {16'd0, damage2}, 32'd0);
        reset = 1'b0;
        bus.hit_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rstoffer_discard", {31'd0, bus.hit_valid}, 32'd0);
        check("rstoffer_d2_after", {16'd0, damage2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
